controlador_estados: RTL and testbench

CONTROLADOR_ESTADOS -- requirements
Module: controlador_estados

---
 rtl/controlador_estados.sv | 156 +++++++++++++++
 tb/tb_controlador_estados.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/controlador_estados.sv
// Virtual-pet state controller: tracks hunger and boredom, reacts to the two
// debounced buttons and reports the current mood code to the image controller.
module controlador_estados #(
    parameter int TICK_CICLOS = 27000000,
    parameter int INTERVALO   = 10,
    parameter int ACAO_TICKS  = 3,
    parameter int MORTE_TICKS = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       b1,
    input  logic       b2,
    output logic [3:0] estado,
    output logic [3:0] fome,
    output logic [3:0] tedio,
    output logic       novo_estado
);

    typedef enum logic [3:0] {
        NORMAL    = 4'b0000,
        COMENDO   = 4'b0001,
        BRINCANDO = 4'b0010,
        FOME      = 4'b0011,
        TRISTE    = 4'b0100,
        MORTO     = 4'b0101
    } estado_t;

    localparam int PRESC_W = (TICK_CICLOS > 1) ? $clog2(TICK_CICLOS) : 1;
    localparam int INTV_W  = (INTERVALO > 1) ? $clog2(INTERVALO) : 1;
    localparam int ACAO_W  = $clog2(ACAO_TICKS + 1);
    localparam int MORTE_W = (MORTE_TICKS > 1) ? $clog2(MORTE_TICKS) : 1;

    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_CICLOS - 1);
    localparam logic [INTV_W-1:0]  INTV_MAX  = INTV_W'(INTERVALO - 1);
    localparam logic [ACAO_W-1:0]  ACAO_LOAD = ACAO_W'(ACAO_TICKS);
    localparam logic [MORTE_W-1:0] MORTE_MAX = MORTE_W'(MORTE_TICKS - 1);

    estado_t            estado_r;
    logic [PRESC_W-1:0] presc_r;
    logic [INTV_W-1:0]  intv_r;
    logic [ACAO_W-1:0]  acao_r;
    logic [MORTE_W-1:0] morte_r;
    logic               b1_prev_r;
    logic               b2_prev_r;

    logic tick_s;
    logic passo_s;
    logic b1_edge_s;
    logic b2_edge_s;
    logic revive_s;

    assign tick_s    = (presc_r == PRESC_MAX);
    assign passo_s   = tick_s && (intv_r == INTV_MAX);
    assign b1_edge_s = b1 & ~b1_prev_r;
    assign b2_edge_s = b2 & ~b2_prev_r;
    assign revive_s  = (estado_r == MORTO) && b1_edge_s && b2_edge_s;
    assign estado    = estado_r;

    // Tick prescaler and hunger/boredom interval counter; reviving restarts both.
    always_ff @(posedge clk) begin
        if (rst || revive_s) begin
            presc_r <= '0;
            intv_r  <= '0;
        end else if (tick_s) begin
            presc_r <= '0;
            intv_r  <= (intv_r == INTV_MAX) ? '0 : intv_r + INTV_W'(1);
        end else begin
            presc_r <= presc_r + PRESC_W'(1);
        end
    end

    // Mood FSM with hunger/boredom levels, action and death timers.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_r    <= NORMAL;
            fome        <= 4'd0;
            tedio       <= 4'd0;
            novo_estado <= 1'b0;
            acao_r      <= '0;
            morte_r     <= '0;
            b1_prev_r   <= b1;
            b2_prev_r   <= b2;
        end else begin
            b1_prev_r   <= b1;
            b2_prev_r   <= b2;
            novo_estado <= 1'b0;
            if (passo_s) begin
                if (estado_r != COMENDO && estado_r != MORTO && fome != 4'd15)
                    fome <= fome + 4'd1;
                if (estado_r != BRINCANDO && estado_r != MORTO && tedio != 4'd15)
                    tedio <= tedio + 4'd1;
            end
            case (estado_r)
                MORTO: begin
                    if (revive_s) begin
                        estado_r    <= NORMAL;
                        novo_estado <= 1'b1;
                        fome        <= 4'd0;
                        tedio       <= 4'd0;
                        acao_r      <= '0;
                        morte_r     <= '0;
                    end
                end
                NORMAL, COMENDO, BRINCANDO, FOME, TRISTE: begin
                    if (b1_edge_s) begin
                        estado_r    <= COMENDO;
                        novo_estado <= (estado_r != COMENDO);
                        fome        <= 4'd0;
                        acao_r      <= ACAO_LOAD;
                        morte_r     <= '0;
                    end else if (b2_edge_s) begin
                        estado_r    <= BRINCANDO;
                        novo_estado <= (estado_r != BRINCANDO);
                        tedio       <= 4'd0;
                        acao_r      <= ACAO_LOAD;
                        morte_r     <= '0;
                    end else if (estado_r == COMENDO || estado_r == BRINCANDO) begin
                        if (tick_s) begin
                            if (acao_r == ACAO_W'(1)) begin
                                estado_r    <= NORMAL;
                                novo_estado <= 1'b1;
                                acao_r      <= '0;
                            end else begin
                                acao_r <= acao_r - ACAO_W'(1);
                            end
                        end
                    end else if (estado_r == FOME) begin
                        if (tick_s && fome == 4'd15) begin
                            if (morte_r == MORTE_MAX) begin
                                estado_r    <= MORTO;
                                novo_estado <= 1'b1;
                                morte_r     <= '0;
                            end else begin
                                morte_r <= morte_r + MORTE_W'(1);
                            end
                        end
                    end else if (fome == 4'd15) begin
                        estado_r    <= FOME;
                        novo_estado <= 1'b1;
                    end else if (estado_r == NORMAL && tedio == 4'd15) begin
                        estado_r    <= TRISTE;
                        novo_estado <= 1'b1;
                    end
                end
                default: begin
                    // Corrupted code: recover to a known mood.
                    estado_r    <= NORMAL;
                    novo_estado <= 1'b1;
                    acao_r      <= '0;
                    morte_r     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_controlador_estados.sv
// Self-checking bench for controlador_estados: directed scenarios plus a
// randomized run against a tick-counting behavioural model.
module tb_controlador_estados;

    localparam int TICK  = 4;
    localparam int INTV  = 2;
    localparam int ACAO  = 3;
    localparam int MORTE = 5;

    logic       clk;
    logic       rst;
    logic       b1;
    logic       b2;
    logic [3:0] estado;
    logic [3:0] fome;
    logic [3:0] tedio;
    logic       novo_estado;

    int n_tests;
    int n_fail;

    // Behavioural model: mood code, levels, and elapsed cycle/tick counts.
    int m_est, m_fome, m_tedio, m_novo;
    int m_clk, m_ticks, m_acao, m_morte;
    int m_prev1, m_prev2;

    controlador_estados #(
        .TICK_CICLOS(TICK),
        .INTERVALO  (INTV),
        .ACAO_TICKS (ACAO),
        .MORTE_TICKS(MORTE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .b1         (b1),
        .b2         (b2),
        .estado     (estado),
        .fome       (fome),
        .tedio      (tedio),
        .novo_estado(novo_estado)
    );

    always #5 clk = ~clk;

    task automatic model_step(input logic b1v, input logic b2v, input logic rv);
        int e1, e2, tick, inc, ns, nf, nt;
        if (rv) begin
            m_est = 0; m_fome = 0; m_tedio = 0; m_novo = 0;
            m_clk = 0; m_ticks = 0; m_acao = 0; m_morte = 0;
            m_prev1 = int'(b1v); m_prev2 = int'(b2v);
            return;
        end
        e1   = (b1v && m_prev1 == 0) ? 1 : 0;
        e2   = (b2v && m_prev2 == 0) ? 1 : 0;
        tick = (m_clk % TICK == TICK - 1) ? 1 : 0;
        inc  = (tick == 1 && (m_ticks % INTV == INTV - 1)) ? 1 : 0;
        m_prev1 = int'(b1v); m_prev2 = int'(b2v);
        ns = m_est; nf = m_fome; nt = m_tedio;
        if (inc == 1) begin
            if (m_est != 1 && m_est != 5) nf = (nf < 15) ? nf + 1 : 15;
            if (m_est != 2 && m_est != 5) nt = (nt < 15) ? nt + 1 : 15;
        end
        m_clk = m_clk + 1;
        if (tick == 1) m_ticks = m_ticks + 1;
        if (m_est == 5) begin
            if (e1 == 1 && e2 == 1) begin
                ns = 0; nf = 0; nt = 0;
                m_clk = 0; m_ticks = 0; m_acao = 0; m_morte = 0;
            end
        end else if (e1 == 1) begin
            ns = 1; nf = 0; m_acao = ACAO; m_morte = 0;
        end else if (e2 == 1) begin
            ns = 2; nt = 0; m_acao = ACAO; m_morte = 0;
        end else if (m_est == 1 || m_est == 2) begin
            if (tick == 1) begin
                m_acao = m_acao - 1;
                if (m_acao == 0) ns = 0;
            end
        end else if (m_est == 3) begin
            if (tick == 1 && m_fome == 15) begin
                m_morte = m_morte + 1;
                if (m_morte == MORTE) begin
                    ns = 5; m_morte = 0;
                end
            end
        end else if (m_fome == 15) begin
            ns = 3;
        end else if (m_est == 0 && m_tedio == 15) begin
            ns = 4;
        end
        m_novo  = (ns != m_est) ? 1 : 0;
        m_est   = ns;
        m_fome  = nf;
        m_tedio = nt;
    endtask

    task automatic cyc(input logic b1v, input logic b2v, input logic rv);
        @(negedge clk);
        b1 = b1v; b2 = b2v; rst = rv;
        @(posedge clk);
        model_step(b1v, b2v, rv);
        #1;
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({estado, fome, tedio, novo_estado} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset: got estado=%b fome=%0d tedio=%0d novo=%b, want all zero",
                     estado, fome, tedio, novo_estado);
        end
    endtask

    task automatic test_feed();
        int bad;
        do_reset();
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        n_tests++;
        if (estado !== 4'b0001 || novo_estado !== 1'b1 || fome !== 4'd0) begin
            n_fail++;
            $display("FAIL feed_enter: got estado=%b novo=%b fome=%0d, want 0001 1 0",
                     estado, novo_estado, fome);
        end
        bad = 0;
        for (int i = 1; i <= 9; i++) begin
            cyc(1'b0, 1'b0, 1'b0);
            if (estado !== 4'b0001 || novo_estado !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL feed_hold: %0d cycles left COMENDO or pulsed early, want 0", bad);
        end
        cyc(1'b0, 1'b0, 1'b0);
        n_tests++;
        if (estado !== 4'b0000 || novo_estado !== 1'b1) begin
            n_fail++;
            $display("FAIL feed_exit: got estado=%b novo=%b, want 0000 1", estado, novo_estado);
        end
        cyc(1'b0, 1'b0, 1'b0);
        n_tests++;
        if (novo_estado !== 1'b0 || {estado, fome, tedio} !== {4'(m_est), 4'(m_fome), 4'(m_tedio)}) begin
            n_fail++;
            $display("FAIL feed_after: got %b/%0d/%0d novo=%b, want %0d/%0d/%0d novo=0",
                     estado, fome, tedio, novo_estado, m_est, m_fome, m_tedio);
        end
    endtask

    task automatic test_both_buttons();
        do_reset();
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b0, 1'b0);
        n_tests++;
        if (tedio !== 4'd2 || fome !== 4'd2) begin
            n_fail++;
            $display("FAIL both_pre: got fome=%0d tedio=%0d, want 2 2", fome, tedio);
        end
        cyc(1'b1, 1'b1, 1'b0);
        n_tests++;
        if (estado !== 4'b0001 || tedio !== 4'd2 || fome !== 4'd0 || novo_estado !== 1'b1) begin
            n_fail++;
            $display("FAIL both_press: got estado=%b fome=%0d tedio=%0d novo=%b, want 0001 0 2 1",
                     estado, fome, tedio, novo_estado);
        end
    endtask

    task automatic test_starve_and_die();
        int bad;
        do_reset();
        for (int i = 0; i < 120; i++) cyc(1'b0, 1'b0, 1'b0);
        n_tests++;
        if (fome !== 4'd15 || tedio !== 4'd15 || estado !== 4'b0000) begin
            n_fail++;
            $display("FAIL starve_levels: got fome=%0d tedio=%0d estado=%b, want 15 15 0000",
                     fome, tedio, estado);
        end
        cyc(1'b0, 1'b0, 1'b0);
        n_tests++;
        if (estado !== 4'b0011 || novo_estado !== 1'b1) begin
            n_fail++;
            $display("FAIL starve_fome: got estado=%b novo=%b, want 0011 1", estado, novo_estado);
        end
        bad = 0;
        for (int i = 0; i < 18; i++) begin
            cyc(1'b0, 1'b0, 1'b0);
            if (estado !== 4'b0011) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL starve_wait: %0d cycles left FOME early, want 0", bad);
        end
        cyc(1'b0, 1'b0, 1'b0);
        n_tests++;
        if (estado !== 4'b0101 || novo_estado !== 1'b1) begin
            n_fail++;
            $display("FAIL starve_morto: got estado=%b novo=%b, want 0101 1", estado, novo_estado);
        end
    endtask

    task automatic test_dead_revive();
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        n_tests++;
        if (estado !== 4'b0101 || novo_estado !== 1'b0) begin
            n_fail++;
            $display("FAIL dead_single: got estado=%b novo=%b, want 0101 0", estado, novo_estado);
        end
        cyc(1'b1, 1'b1, 1'b0);
        n_tests++;
        if (estado !== 4'b0000 || fome !== 4'd0 || tedio !== 4'd0 || novo_estado !== 1'b1) begin
            n_fail++;
            $display("FAIL dead_revive: got estado=%b fome=%0d tedio=%0d novo=%b, want 0000 0 0 1",
                     estado, fome, tedio, novo_estado);
        end
        for (int i = 0; i < 9; i++) cyc(1'b0, 1'b0, 1'b0);
        n_tests++;
        if (fome !== 4'd1 || tedio !== 4'd1) begin
            n_fail++;
            $display("FAIL revive_timers: got fome=%0d tedio=%0d, want 1 1", fome, tedio);
        end
    endtask

    task automatic test_hold_through_reset();
        int bad;
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            if (estado !== 4'b0000 || novo_estado !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL hold_reset: %0d cycles showed an edge, want 0", bad);
        end
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        n_tests++;
        if (estado !== 4'b0001 || novo_estado !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_repress: got estado=%b novo=%b, want 0001 1", estado, novo_estado);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        cyc(1'b0, 1'b1, 1'b0);
        n_tests++;
        if (estado !== 4'b0010 || novo_estado !== 1'b1 || tedio !== 4'd0) begin
            n_fail++;
            $display("FAIL b2b_play: got estado=%b novo=%b, want 0010 1", estado, novo_estado);
        end
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        n_tests++;
        if (estado !== 4'b0001 || novo_estado !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_feed: got estado=%b novo=%b, want 0001 1", estado, novo_estado);
        end
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        n_tests++;
        if (estado !== 4'b0001 || novo_estado !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_reenter: got estado=%b novo=%b, want 0001 0", estado, novo_estado);
        end
        cyc(1'b1, 1'b1, 1'b0);
        n_tests++;
        if (estado !== 4'b0010 || novo_estado !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_b2_only_edge: got estado=%b novo=%b, want 0010 1", estado, novo_estado);
        end
    endtask

    task automatic test_random();
        logic rb1, rb2, rr;
        int   busy, shown;
        rb1 = 1'b0; rb2 = 1'b0; busy = 1; shown = 0;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if (i % 200 == 0) busy = int'($urandom_range(0, 1));
            if (busy == 1) begin
                if ($urandom_range(0, 5) == 0) rb1 = ~rb1;
                if ($urandom_range(0, 5) == 0) rb2 = ~rb2;
            end else if ($urandom_range(0, 63) == 0) begin
                rb2 = ~rb2;
            end
            rr = ($urandom_range(0, 699) == 0);
            cyc(rb1, rb2, rr);
            n_tests++;
            if ({estado, fome, tedio, novo_estado} !==
                {4'(m_est), 4'(m_fome), 4'(m_tedio), 1'(m_novo)}) begin
                n_fail++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL random[%0d]: got estado=%b fome=%0d tedio=%0d novo=%b, want %0d %0d %0d %0d",
                             i, estado, fome, tedio, novo_estado, m_est, m_fome, m_tedio, m_novo);
                end
            end
        end
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1; b1 = 1'b0; b2 = 1'b0;
        n_tests = 0; n_fail = 0;
        test_reset();
        test_feed();
        test_both_buttons();
        test_starve_and_die();
        test_dead_revive();
        test_hold_through_reset();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
